// File: rtl/mem_writeback_pkg.sv
// mem_writeback shared types and defaults.
// Also imported by the SDRAM loader.
package mem_writeback_pkg;

  localparam logic [21:0] DEF_SDRAM_OFFSET  = 22'h31E000;
  localparam logic [8:0]  DEF_MEM_ADDR_MAX1 = 9'h047;
  localparam logic [8:0]  DEF_MEM_ADDR_MAX2 = 9'h1CE;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    MEM_RD,
    MEM_LAT,
    WRITE,
    NEXT,
    DONE
  } wb_state_e;

endpackage

// File: rtl/mem_writeback_if.sv
// Bundle between mem_writeback, on-chip banks
// and the SDRAM controller.
interface mem_writeback_if;

  logic         start;
  logic         sdram_wait;
  logic         sdram_ac;
  logic [127:0] mem_q;
  logic [127:0] mem_q1;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic [8:0]   mem_addr;
  logic         mem_rd;
  logic         mem_rd1;
  logic         busy;
  logic         done;

  modport master (
    input  start,
    input  sdram_wait,
    input  sdram_ac,
    input  mem_q,
    input  mem_q1,
    output sdram_wr,
    output sdram_addr,
    output sdram_wdata,
    output mem_addr,
    output mem_rd,
    output mem_rd1,
    output busy,
    output done
  );

  modport slave (
    output start,
    output sdram_wait,
    output sdram_ac,
    output mem_q,
    output mem_q1,
    input  sdram_wr,
    input  sdram_addr,
    input  sdram_wdata,
    input  mem_addr,
    input  mem_rd,
    input  mem_rd1,
    input  busy,
    input  done
  );

endinterface

// File: rtl/mem_writeback.sv
// Copies on-chip bank 0 then bank 1 to
// consecutive SDRAM words, one word per write.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter logic [21:0] SDRAM_OFFSET  = DEF_SDRAM_OFFSET,
  parameter logic [8:0]  MEM_ADDR_MAX1 = DEF_MEM_ADDR_MAX1,
  parameter logic [8:0]  MEM_ADDR_MAX2 = DEF_MEM_ADDR_MAX2
) (
  input logic            clk,
  input logic            reset,
  mem_writeback_if.master bus
);

  wb_state_e    state_q, state_d;
  logic         bank_q, bank_d;
  logic [8:0]   mem_addr_q, mem_addr_d;
  logic [21:0]  sdram_addr_q, sdram_addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic         wr_q, rd_q, rd1_q;
  logic         busy_q, done_q;
  logic         last_b0, last_b1;

  assign last_b0 = !bank_q && (mem_addr_q == MEM_ADDR_MAX1);
  assign last_b1 =  bank_q && (mem_addr_q == MEM_ADDR_MAX2);

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    mem_addr_d   = mem_addr_q;
    sdram_addr_d = sdram_addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        sdram_addr_d = SDRAM_OFFSET;
        mem_addr_d   = '0;
        bank_d       = 1'b0;
        if (bus.start) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!bus.sdram_wait) state_d = MEM_RD;
      end
      MEM_RD: state_d = MEM_LAT;
      MEM_LAT: begin
        wdata_d = bank_q ? bus.mem_q1 : bus.mem_q;
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.sdram_ac) state_d = NEXT;
      end
      NEXT: begin
        // final word: park on the base address, never step past it
        if (last_b1) begin
          sdram_addr_d = SDRAM_OFFSET;
          mem_addr_d   = '0;
          bank_d       = 1'b0;
          state_d      = DONE;
        end else begin
          sdram_addr_d = sdram_addr_q + 22'd1;
          state_d      = MEM_RD;
          if (last_b0) begin
            bank_d     = 1'b1;
            mem_addr_d = '0;
          end else begin
            mem_addr_d = mem_addr_q + 9'd1;
          end
        end
      end
      DONE: begin
        sdram_addr_d = SDRAM_OFFSET;
        mem_addr_d   = '0;
        bank_d       = 1'b0;
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // strobes are registered copies of the next-state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bank_q       <= 1'b0;
      mem_addr_q   <= '0;
      sdram_addr_q <= SDRAM_OFFSET;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      rd1_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      mem_addr_q   <= mem_addr_d;
      sdram_addr_q <= sdram_addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= (state_d == WRITE);
      rd_q         <= (state_d == MEM_RD) && !bank_d;
      rd1_q        <= (state_d == MEM_RD) &&  bank_d;
      busy_q       <= (state_d != IDLE) && (state_d != DONE);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.sdram_wr    = wr_q;
  assign bus.sdram_addr  = sdram_addr_q;
  assign bus.sdram_wdata = wdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_rd1     = rd1_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
